// File: rtl/conditioned_shift_unit.sv
// rtl/conditioned_shift_unit.sv - debounced WIDTH-bit bidirectional shift register; define CSU_FRAME_COUNT_EN for frame counter/frame_done

// Synchronise, debounce and edge-detect one raw board input.
module csu_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_smooth,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_smooth;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sync_out;
    logic w_differ;
    logic w_settled;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differ   = w_sync_out ^ r_smooth;
    // The synchronised level has disagreed for WAIT_CYCLES edges including this one.
    assign w_settled  = w_differ && (r_cnt == LP_CNT_LAST);

    // Metastability chain: raw input enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Debounce: count consecutive disagreeing cycles, any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_smooth <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= w_settled & w_sync_out;
            r_fall <= w_settled & ~w_sync_out;
            if (w_settled) begin
                r_smooth <= w_sync_out;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_smooth = r_smooth;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// Board-facing wrapper: three conditioned inputs driving the shift register.
module conditioned_shift_unit #(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] LOAD_VALUE  = 32'hA5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_load,
    input  logic             sw_serial,
    input  logic             sw_shift,
    input  logic             dir,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             frame_done
);

    localparam logic [WIDTH-1:0] LP_LOAD = WIDTH'(LOAD_VALUE);

    logic w_load_smooth;
    logic w_load_rise;
    logic w_load_fall;
    logic w_serial_smooth;
    logic w_serial_rise;
    logic w_serial_fall;
    logic w_shift_smooth;
    logic w_shift_rise;
    logic w_shift_fall;

    logic w_load_evt;
    logic w_shift_evt;
    logic w_unused_cond;

    logic [WIDTH-1:0] r_shift;

    csu_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_cond_load (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raw    (btn_load),
        .o_smooth (w_load_smooth),
        .o_rise   (w_load_rise),
        .o_fall   (w_load_fall)
    );

    csu_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_cond_serial (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raw    (sw_serial),
        .o_smooth (w_serial_smooth),
        .o_rise   (w_serial_rise),
        .o_fall   (w_serial_fall)
    );

    csu_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_cond_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raw    (sw_shift),
        .o_smooth (w_shift_smooth),
        .o_rise   (w_shift_rise),
        .o_fall   (w_shift_fall)
    );

    // Load fires on button release; shift fires on the shift switch going high.
    assign w_load_evt  = w_load_fall;
    assign w_shift_evt = w_shift_rise;

    // Conditioner outputs this wrapper has no use for.
    assign w_unused_cond = ^{w_load_smooth, w_load_rise, w_serial_rise, w_serial_fall,
                             w_shift_smooth, w_shift_fall};

    // Shift register: load beats shift when both arrive in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
        end else if (w_load_evt) begin
            r_shift <= LP_LOAD;
        end else if (w_shift_evt) begin
            if (dir) begin
                r_shift <= {w_serial_smooth, r_shift[WIDTH-1:1]};
            end else begin
                r_shift <= {r_shift[WIDTH-2:0], w_serial_smooth};
            end
        end
    end

    assign parallel_out = r_shift;
    // Bit leaving the register follows dir without waiting for a clock.
    assign serial_out   = dir ? r_shift[0] : r_shift[WIDTH-1];

`ifdef CSU_FRAME_COUNT_EN
    localparam int FC_W = $clog2(WIDTH + 1);
    localparam logic [FC_W-1:0] LP_FC_LAST = FC_W'(WIDTH - 1);

    logic [FC_W-1:0] r_frame_cnt;
    logic            r_frame_done;

    // Count accepted shifts; a load restarts the frame and a dropped shift is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_load_evt) begin
                r_frame_cnt <= '0;
            end else if (w_shift_evt) begin
                if (r_frame_cnt == LP_FC_LAST) begin
                    r_frame_cnt  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign frame_done = r_frame_done;
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_conditioned_shift_unit.sv
// tb/tb_conditioned_shift_unit.sv - table-driven and sequence checks for conditioned_shift_unit
module tb_conditioned_shift_unit;

`ifdef CSU_FRAME_COUNT_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       btn_load;
    logic       sw_serial;
    logic       sw_shift;
    logic       dir;
    logic [7:0] parallel_out;
    logic       serial_out;
    logic       frame_done;

    int checks;
    int failures;

    typedef struct {
        logic       btn;
        logic       ser;
        logic       sh;
        logic       dr;
        int         hold;
        logic [7:0] par;
        logic       sout;
        logic       fd;
    } vec_t;

    vec_t vecs[14];

    conditioned_shift_unit #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .WAIT_CYCLES (3),
        .LOAD_VALUE  (32'hA5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_load     (btn_load),
        .sw_serial    (sw_serial),
        .sw_shift     (sw_shift),
        .dir          (dir),
        .parallel_out (parallel_out),
        .serial_out   (serial_out),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        btn_load  = 1'b0;
        sw_serial = 1'b0;
        sw_shift  = 1'b0;
        dir       = 1'b0;

        //           btn   ser   sh    dir  hold par    sout  fd
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 8'hA5, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 8'h4B, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 8'h4B, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  0, 8'h4B, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0,  0, 8'h4B, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 8'h4B, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 8'hA5, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1,  0, 8'hA5, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 8'h52, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 8'h52, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0,  0, 8'h52, 1'b0, 1'b0};

        // Reset state
        wait_neg(3);
        chk("reset_par", 32'(parallel_out), 32'h00);
        chk("reset_sout", 32'(serial_out), 32'h0);
        chk("reset_fd", 32'(frame_done), 32'h0);
        reset_n = 1'b1;
        wait_neg(1);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            btn_load  = vecs[i].btn;
            sw_serial = vecs[i].ser;
            sw_shift  = vecs[i].sh;
            dir       = vecs[i].dr;
            wait_neg(vecs[i].hold);
            #1;
            chk($sformatf("vec%0d_par", i), 32'(parallel_out), 32'(vecs[i].par));
            chk($sformatf("vec%0d_sout", i), 32'(serial_out), 32'(vecs[i].sout));
            chk($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(vecs[i].fd));
        end

        // Asynchronous reset in the middle of a cycle
        wait_neg(1);
        btn_load = 1'b0; sw_serial = 1'b0; sw_shift = 1'b0; dir = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_par", 32'(parallel_out), 32'h00);
        chk("async_reset_sout", 32'(serial_out), 32'h0);
        chk("async_reset_fd", 32'(frame_done), 32'h0);
        wait_neg(1);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_neg(1);
            chk($sformatf("post_reset_c%0d", k), {23'd0, frame_done, serial_out, parallel_out}, 32'h0);
        end

        // Load latency: press has no effect, release loads on the 6th edge
        btn_load = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_neg(1);
            chk($sformatf("press_c%0d", k), 32'(parallel_out), 32'h00);
        end
        btn_load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wait_neg(1);
            chk($sformatf("load_lat_e%0d", k), 32'(parallel_out), (k < 6) ? 32'h00 : 32'hA5);
        end
        chk("load_sout", 32'(serial_out), 32'h1);

        // Debounce: 2-cycle glitches are rejected, a 3-cycle high shifts once
        sw_serial = 1'b1;
        wait_neg(10);
        for (int g = 0; g < 5; g++) begin
            sw_shift = 1'b1;
            wait_neg(2);
            sw_shift = 1'b0;
            wait_neg(2);
        end
        wait_neg(10);
        chk("glitch_par", 32'(parallel_out), 32'hA5);
        sw_shift = 1'b1;
        wait_neg(3);
        sw_shift = 1'b0;
        wait_neg(10);
        chk("stable3_par", 32'(parallel_out), 32'h4B);

        // Load and shift pulses in the same cycle: load wins
        btn_load  = 1'b1;
        sw_serial = 1'b0;
        wait_neg(10);
        chk("prio_pre_par", 32'(parallel_out), 32'h4B);
        btn_load = 1'b0;
        sw_shift = 1'b1;
        wait_neg(10);
        chk("prio_par", 32'(parallel_out), 32'hA5);
        sw_shift = 1'b0;
        wait_neg(10);
        chk("prio_hold_par", 32'(parallel_out), 32'hA5);

        // Eight left shifts of zero; frame_done only in the cycle after the 8th
        for (int s = 0; s < 8; s++) begin
            sw_shift = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                wait_neg(1);
                chk($sformatf("frame_s%0d_c%0d_fd", s, k), 32'(frame_done),
                    32'(FRAME_EN && (s == 7) && (k == 6)));
                if (s == 7 && k == 5) chk("frame_pre_par", 32'(parallel_out), 32'h80);
                if (s == 7 && k == 6) chk("frame_last_par", 32'(parallel_out), 32'h00);
            end
            sw_shift = 1'b0;
            wait_neg(10);
        end
        chk("frame_after_fd", 32'(frame_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
